fp_addsub_unit: RTL and testbench
=================================

FP_ADDSUB_UNIT -- requirements
Module: fp_addsub_unit

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 Parameter MAN_W, default 23, stored fraction width (>=4); W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and op are valid.
REQ-006 in_ready  output  1  unit can accept an operation.
REQ-007 a  input  W  operand A, IEEE-754 style {sign, exp, frac}.
REQ-008 b  input  W  operand B, same format.
REQ-009 op  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  W  rounded sum or difference.
REQ-013 flags  output  4  {invalid, overflow, underflow, inexact}; present only with FP_ADDSUB_FLAGS_EN.

Function
REQ-014 Accept on the in_valid&&in_ready edge: capture a, b, op, and b's sign XOR op.
REQ-015 FSM: IDLE->ALIGN->OPERATE->NORMALIZE->ROUND->OUTPUT, one cycle per state except OUTPUT; OUTPUT->IDLE on out_valid&&out_ready.
REQ-016 in_ready is 1 only in IDLE; out_valid is 1 only in OUTPUT.
REQ-017 Fixed latency for every input class, specials included: out_valid rises 5 cycles after the accepting edge.
REQ-018 result and flags are held stable while out_valid=1 and out_ready=0.
REQ-019 ALIGN: swap operands so A has the larger magnitude (exp, then frac); right-shift the smaller significand by the exponent difference.
REQ-020 Alignment datapath: MAN_W+4 bits (hidden bit, fraction, G, R); S is the OR of all bits shifted out.
REQ-021 Shift amounts >= MAN_W+3 saturate, leaving only S set when the smaller operand is non-zero.
REQ-022 OPERATE: add significands when effective signs match, else subtract; one carry bit is kept.
REQ-023 NORMALIZE: on carry-out, shift right 1 (folding the lost bit into S) and increment exp.
REQ-024 NORMALIZE otherwise: shift left by the leading-zero count and decrement exp, computed in one cycle.
REQ-025 ROUND: round-to-nearest-even using G, R, S; a rounding carry renormalises and increments exp.
REQ-026 Exact zero from opposite signs gives +0; zero plus zero of equal sign keeps that sign.
REQ-027 Subnormal inputs (exp=0) are treated as signed zero.
REQ-028 A result whose final exponent is <= 0 flushes to signed zero and sets underflow.
REQ-029 A final exponent >= all-ones gives signed infinity and sets overflow and inexact.
REQ-030 Any NaN input, or Inf minus Inf, gives canonical quiet NaN {0, all-ones, 1 followed by zeros} and sets invalid.
REQ-031 Inf with a finite operand gives that Inf.
REQ-032 inexact is set when any of G, R, S is non-zero before rounding.

Reset
REQ-033 While reset_n=0: state IDLE, in_ready=1, out_valid=0, result=0, flags=0, all datapath registers 0.
REQ-034 Reset asserted mid-operation aborts the operation; no result is produced after release.
REQ-035 First acceptance is possible on the first rising edge after reset_n deasserts.

Configuration
REQ-036 Macro FP_ADDSUB_FLAGS_EN defined: the flags port exists and is registered with result.
REQ-037 Macro FP_ADDSUB_FLAGS_EN undefined: no flags port and no flag logic; result is bit-identical and latency is unchanged.

Verification (EXP_W=8, MAN_W=23, FLAGS_EN defined)
REQ-038 a=0x3F800000, b=0x40000000, op=0 -> result 0x40400000, flags 0, out_valid 5 cycles after accept.
REQ-039 a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000; a=0x3F800001, b=0x33800000, op=0 -> result 0x3F800002, inexact=1 (tie to even).
REQ-040 a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> result 0x7F800000, flags 0b0101; a=0x7F800000, b=0x7F800000, op=1 -> result 0x7FC00000, flags 0b1000.
REQ-041 Hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, back-to-back op accepted.
REQ-042 Drop reset_n 2 cycles after accept -> out_valid stays 0 and no spurious result after release.

Source files
------------

// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 style adder/subtractor (flush-to-zero, round-to-nearest-even).
// Define FP_ADDSUB_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module fp_addsub_unit #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result
`ifdef FP_ADDSUB_FLAGS_EN
   ,
   output logic [3:0]   flags
`endif
);

   localparam int SIG_W = MAN_W + 4;
   localparam int LZW = $clog2(SIG_W + 1);
   localparam int XW = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
   localparam logic signed [XW-1:0] EXP_MAX = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_OPERATE, S_NORMALIZE, S_ROUND, S_OUTPUT} state_t;

   function automatic logic [SIG_W-1:0] align_shift(input logic [SIG_W-1:0] v, input logic [EXP_W-1:0] d);
      logic [2*SIG_W-1:0] t;
      if ({{(32-EXP_W){1'b0}}, d} >= 32'(SIG_W - 1))
         return {{(SIG_W-1){1'b0}}, |v};
      t = {v, {SIG_W{1'b0}}} >> d;
      return {t[2*SIG_W-1:SIG_W+1], t[SIG_W] | (|t[SIG_W-1:0])};
   endfunction

   function automatic int lzc(input logic [SIG_W-1:0] v);
      int n;
      n = SIG_W;
      for (int i = 0; i < SIG_W; i++)
         if (v[i]) n = SIG_W - 1 - i;
      return n;
   endfunction

   // Returns {carry, hidden, fraction} after round-to-nearest-even on G/R/S.
   function automatic logic [MAN_W+1:0] round_rne(input logic [SIG_W-1:0] s);
      logic up;
      up = s[2] & (s[1] | s[0] | s[3]);
      return {1'b0, s[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, up};
   endfunction

   function automatic logic [W-1:0] saturate(input logic s, input logic signed [XW-1:0] e,
                                             input logic [MAN_W-1:0] f);
      if (e[XW-1] || e == '0) return {s, {(W-1){1'b0}}};
      if (e >= EXP_MAX)       return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      return {s, e[EXP_W-1:0], f};
   endfunction

   state_t state;
   logic [W-1:0]           a_p0, b_p0;
   logic [EXP_W-1:0]       exp_p1;
   logic [SIG_W-1:0]       big_p1, small_p1;
   logic                   sign_p1, sub_p1, spec_p1;
   logic [W-1:0]           spec_res_p1;
   logic [SIG_W:0]         sum_p2;
   logic [SIG_W-1:0]       nsig_p3;
   logic signed [XW-1:0]   nexp_p3;
   logic                   zero_p3;
`ifdef FP_ADDSUB_FLAGS_EN
   logic                   inv_p1;
   logic [3:0]             flags_n;
`endif

   // ALIGN: classify, order by magnitude, shift the smaller significand
   logic [EXP_W-1:0] ea, eb, big_e, small_e;
   logic [MAN_W-1:0] fa, fb;
   logic             a_z, b_z, a_inf, b_inf, a_nan, b_nan, sa, sb, swap, inv_n;
   logic [MAN_W:0]   sig_a, sig_b;
   logic [SIG_W-1:0] big_n, small_n;
   logic [W-1:0]     spec_res_n;

   always_comb begin
      ea = a_p0[W-2:MAN_W];
      eb = b_p0[W-2:MAN_W];
      fa = a_p0[MAN_W-1:0];
      fb = b_p0[MAN_W-1:0];
      sa = a_p0[W-1];
      sb = b_p0[W-1];
      a_z = (ea == '0);
      b_z = (eb == '0);
      a_inf = (&ea) && (fa == '0);
      b_inf = (&eb) && (fb == '0);
      a_nan = (&ea) && (fa != '0);
      b_nan = (&eb) && (fb != '0);
      sig_a = a_z ? '0 : {1'b1, fa};
      sig_b = b_z ? '0 : {1'b1, fb};
      swap = (b_z ? '0 : b_p0[W-2:0]) > (a_z ? '0 : a_p0[W-2:0]);
      big_e = swap ? eb : ea;
      small_e = swap ? ea : eb;
      big_n = {(swap ? sig_b : sig_a), 3'b000};
      small_n = align_shift({(swap ? sig_a : sig_b), 3'b000}, big_e - small_e);
      inv_n = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
      if (inv_n)      spec_res_n = QNAN;
      else if (a_inf) spec_res_n = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else            spec_res_n = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   end

   // OPERATE / NORMALIZE
   logic [SIG_W:0]       sum_n;
   logic [SIG_W-1:0]     nsig_n;
   logic signed [XW-1:0] exp_x, nexp_n;
   int                   lz;

   always_comb begin
      sum_n = sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1}) : ({1'b0, big_p1} + {1'b0, small_p1});
      exp_x = {{(XW-EXP_W){1'b0}}, exp_p1};
      lz = lzc(sum_p2[SIG_W-1:0]);
      if (sum_p2[SIG_W]) begin
         nsig_n = {sum_p2[SIG_W:2], sum_p2[1] | sum_p2[0]};
         nexp_n = exp_x + XW'(1);
      end else begin
         nsig_n = sum_p2[SIG_W-1:0] << lz;
         nexp_n = exp_x - XW'(lz);
      end
   end

   // ROUND: rounding, renormalisation, range handling, specials
   logic [MAN_W+1:0]     rm;
   logic [MAN_W-1:0]     rfrac;
   logic signed [XW-1:0] rexp;
   logic [W-1:0]         res_n;

   always_comb begin
      rm = round_rne(nsig_p3);
      rfrac = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
      rexp = rm[MAN_W+1] ? nexp_p3 + XW'(1) : nexp_p3;
      if (spec_p1)      res_n = spec_res_p1;
      else if (zero_p3) res_n = {(sub_p1 ? 1'b0 : sign_p1), {(W-1){1'b0}}};
      else              res_n = saturate(sign_p1, rexp, rfrac);
`ifdef FP_ADDSUB_FLAGS_EN
      flags_n = '0;
      if (spec_p1)                        flags_n = {inv_p1, 3'b000};
      else if (zero_p3)                   flags_n = '0;
      else if (rexp[XW-1] || rexp == '0)  flags_n = {2'b00, 1'b1, |nsig_p3[2:0]};
      else if (rexp >= EXP_MAX)           flags_n = 4'b0101;
      else                                flags_n = {3'b000, |nsig_p3[2:0]};
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         a_p0 <= '0;
         b_p0 <= '0;
         exp_p1 <= '0;
         big_p1 <= '0;
         small_p1 <= '0;
         sign_p1 <= 1'b0;
         sub_p1 <= 1'b0;
         spec_p1 <= 1'b0;
         spec_res_p1 <= '0;
         sum_p2 <= '0;
         nsig_p3 <= '0;
         nexp_p3 <= '0;
         zero_p3 <= 1'b0;
         result <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
         inv_p1 <= 1'b0;
         flags <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_p0 <= a;
               b_p0 <= {b[W-1] ^ op, b[W-2:0]};
               in_ready <= 1'b0;
               state <= S_ALIGN;
            end
            S_ALIGN: begin
               exp_p1 <= big_e;
               big_p1 <= big_n;
               small_p1 <= small_n;
               sign_p1 <= swap ? sb : sa;
               sub_p1 <= (sa != sb);
               spec_p1 <= inv_n | a_inf | b_inf;
               spec_res_p1 <= spec_res_n;
`ifdef FP_ADDSUB_FLAGS_EN
               inv_p1 <= inv_n;
`endif
               state <= S_OPERATE;
            end
            S_OPERATE: begin
               sum_p2 <= sum_n;
               state <= S_NORMALIZE;
            end
            S_NORMALIZE: begin
               nsig_p3 <= nsig_n;
               nexp_p3 <= nexp_n;
               zero_p3 <= (sum_p2 == '0);
               state <= S_ROUND;
            end
            S_ROUND: begin
               result <= res_n;
`ifdef FP_ADDSUB_FLAGS_EN
               flags <= flags_n;
`endif
               out_valid <= 1'b1;
               state <= S_OUTPUT;
            end
            S_OUTPUT: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               in_ready <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit (binary32); flag checks compile in with FP_ADDSUB_FLAGS_EN.
module tb_fp_addsub_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
`ifdef FP_ADDSUB_FLAGS_EN
   logic [3:0]  flags;
`endif

   int checks = 0;
   int errors = 0;

   fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .op(op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result)
`ifdef FP_ADDSUB_FLAGS_EN
      ,
      .flags(flags)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One operation: accept, expect out_valid in the 5th cycle after accept, check result/flags.
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                         input logic [31:0] eres, input logic [3:0] efl, input string tag,
                         input bit do_release);
      int n;
      int cyc;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      a = ia;
      b = ib;
      op = iop;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd5);
      check({tag, "_result"}, result, eres);
`ifdef FP_ADDSUB_FLAGS_EN
      check({tag, "_flags"}, {28'b0, flags}, {28'b0, efl});
`endif
      if (do_release) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check({tag, "_out_valid_clr"}, {31'b0, out_valid}, 32'd0);
         check({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
      end
   endtask

   initial begin
      int seen;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
`ifdef FP_ADDSUB_FLAGS_EN
      check("rst_flags", {28'b0, flags}, 32'd0);
`endif
      reset_n = 1'b1;

      run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "one_plus_two", 1);
      run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "one_minus_one", 1);
      run_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie_odd_up", 1);
      run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even_keep", 1);
      run_op(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001, "round_carry", 1);
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow", 1);
      run_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, "inf_minus_inf", 1);
      run_op(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "nan_in", 1);
      run_op(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, "ninf_plus_one", 1);
      run_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "three_minus_one", 1);
      run_op(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, "one_minus_two", 1);
      run_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "nzero_nzero", 1);
      run_op(32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, "subnormal_zero", 1);
      run_op(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0010, "underflow", 1);
      run_op(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001, "sat_shift", 1);

      // backpressure: hold result for 10 cycles, then release and go back-to-back
      run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "hold", 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_result", result, 32'h40400000);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hold_release_idle", {31'b0, in_ready}, 32'd1);
      run_op(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, "back_to_back", 1);

      // reset mid-operation
      a = 32'h3F800000;
      b = 32'h40000000;
      op = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_in_ready", {31'b0, in_ready}, 32'd1);
      check("abort_result", result, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_spurious", 32'(seen), 32'd0);
      run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, "after_abort", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
